// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   WIDTH      : operand/result width (32 only)
//   ALU_*      : 5-bit ALU control codes, same values the ALU control decoder emits
//   state_e    : sequencing states of alu_exec_unit
//   magnitude(): absolute value of a two's-complement operand when signed
package alu_pkg;
    localparam int WIDTH = 32;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_XOR = 5'b01101;
    localparam logic [4:0] ALU_SLL = 5'b10000;
    localparam logic [4:0] ALU_SRL = 5'b11000;
    localparam logic [4:0] ALU_SRA = 5'b11001;
    localparam logic [4:0] ALU_MUL = 5'b11010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_ITER = 2'd1,
        ST_MUL_FIX  = 2'd2
    } state_e;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: issue/result bundle between the pipeline and alu_exec_unit.
//   master (pipeline side): drives flush, in_valid, ALUCtl, Sign, in1, in2;
//                           sees in_ready, out_valid, result, hi, zero, stall
//   slave  (ALU side)     : the mirror image
interface alu_exec_unit_if;
    import alu_pkg::*;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       ALUCtl;
    logic             Sign;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             stall;

    modport master (
        output flush, in_valid, ALUCtl, Sign, in1, in2,
        input  in_ready, out_valid, result, hi, zero, stall
    );

    modport slave (
        input  flush, in_valid, ALUCtl, Sign, in1, in2,
        output in_ready, out_valid, result, hi, zero, stall
    );
endinterface

// File: rtl/alu_seq_multiplier.sv
// alu_seq_multiplier: unsigned WIDTH x WIDTH shift-add multiplier, one
// multiplier bit per clock.
//   clk       : clock
//   clear_i   : synchronous abort (reset or pipeline flush), drops busy
//   start_i   : load operands; bit 0 of b_i is consumed on this same edge
//   a_i, b_i  : unsigned multiplicand / multiplier
//   product_o : 2*WIDTH product, valid on the cycle after last_o
//   last_o    : high during the cycle whose edge consumes bit 31
// Bits 1..31 are consumed on the following 31 edges, so the product is
// complete 32 edges after start_i.
module alu_seq_multiplier
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               last_o
);
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;     // {partial sum, remaining multiplier bits}
    logic [4:0]         cnt_q;      // multiplier bit consumed on the next edge
    logic               busy_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] step_prod;
    logic [WIDTH-1:0]   first_pp;
    logic [2*WIDTH-1:0] load_prod;

    assign addend    = prod_q[0] ? mcand_q : '0;
    assign sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign step_prod = {sum, prod_q[WIDTH-1:1]};

    // Loading folds in the bit-0 step so all 32 bits fit in 32 edges.
    assign first_pp  = b_i[0] ? a_i : '0;
    assign load_prod = {1'b0, first_pp, b_i[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (clear_i) begin
            busy_q  <= 1'b0;
            cnt_q   <= 5'd0;
            prod_q  <= '0;
            mcand_q <= '0;
        end else if (start_i) begin
            mcand_q <= a_i;
            prod_q  <= load_prod;
            cnt_q   <= 5'd1;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            prod_q <= step_prod;
            if (cnt_q == 5'd31) begin
                busy_q <= 1'b0;
                cnt_q  <= 5'd0;
            end else begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    assign product_o = prod_q;
    assign last_o    = busy_q && (cnt_q == 5'd31);
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered result and a sequential
// multiplier.
//   clk, reset : clock, synchronous active-high reset
//   bus        : alu_exec_unit_if.slave (issue operands/code, result, hi,
//                zero, in_ready/stall handshake, flush)
// Single-cycle ops write result one clock after issue. MUL issues into
// MUL_ITER, runs the unsigned multiplier on operand magnitudes, then
// MUL_FIX applies the sign and writes {hi, result}.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               out_valid_q, out_valid_d;
    logic               neg_q, neg_d;

    logic               accept;
    logic               is_mul;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   alu_res;
    logic               slt_lt;

    // Flush wins over a same-cycle issue.
    assign accept = bus.in_valid && (state_q == ST_IDLE) && !bus.flush;
    assign is_mul = (bus.ALUCtl == ALU_MUL);

    alu_seq_multiplier u_mul (
        .clk       (clk),
        .clear_i   (reset || bus.flush),
        .start_i   (accept && is_mul),
        .a_i       (magnitude(bus.in1, bus.Sign)),
        .b_i       (magnitude(bus.in2, bus.Sign)),
        .product_o (mul_prod),
        .last_o    (mul_last)
    );

    assign prod_fixed = neg_q ? (~mul_prod + (2*WIDTH)'(1)) : mul_prod;

    assign slt_lt = bus.Sign ? ($signed(bus.in1) < $signed(bus.in2))
                             : (bus.in1 < bus.in2);

    always_comb begin
        alu_res = '0;
        case (bus.ALUCtl)
            ALU_AND: alu_res = bus.in1 & bus.in2;
            ALU_OR:  alu_res = bus.in1 | bus.in2;
            ALU_ADD: alu_res = bus.in1 + bus.in2;
            ALU_SUB: alu_res = bus.in1 - bus.in2;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
            ALU_NOR: alu_res = ~(bus.in1 | bus.in2);
            ALU_XOR: alu_res = bus.in1 ^ bus.in2;
            ALU_SLL: alu_res = bus.in2 << bus.in1[4:0];
            ALU_SRL: alu_res = bus.in2 >> bus.in1[4:0];
            ALU_SRA: alu_res = WIDTH'($signed(bus.in2) >>> bus.in1[4:0]);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        hi_d        = hi_q;
        out_valid_d = 1'b0;
        neg_d       = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = ST_MUL_ITER;
                        neg_d   = bus.Sign && (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
                    end else begin
                        result_d    = alu_res;
                        hi_d        = '0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL_ITER: begin
                if (mul_last) state_d = ST_MUL_FIX;
            end
            ST_MUL_FIX: begin
                {hi_d, result_d} = prod_fixed;
                out_valid_d      = 1'b1;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A flush discards whatever this cycle would have written.
        if (bus.flush) begin
            state_d     = ST_IDLE;
            result_d    = result_q;
            hi_d        = hi_q;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            hi_q        <= '0;
            out_valid_q <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            out_valid_q <= out_valid_d;
            neg_q       <= neg_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.stall     = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.hi        = hi_q;
    assign bus.zero      = (result_q == '0);
endmodule
